sad_window_feeder: RTL

//  Producer side of the 4x4 SAD datapath. Reads a 16-pixel template (Crop) and a frame from a

---
 rtl/sad_pkg.sv | 21 ++
 rtl/sad_pixel_fetch.sv | 57 +++++
 rtl/sad_window_feeder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared widths, FSM encodings and pixel indexing for the 4x4 SAD window datapath.
package sad_pkg;
    localparam int BLK      = 4;
    localparam int PIX_W    = 8;
    localparam int BLK_BITS = BLK * BLK * PIX_W;
    localparam int IDX_W    = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_LOAD_TMPL = 3'd1;
    localparam state_t S_LOAD_FULL = 3'd2;
    localparam state_t S_PRESENT   = 3'd3;
    localparam state_t S_LOAD_COL  = 3'd4;
    localparam state_t S_DONE      = 3'd5;

    // Row-major position of pixel (row, col) inside a 4x4 block.
    function automatic logic [IDX_W-1:0] pix_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/sad_pixel_fetch.sv
// Sequential pixel reader: 16 reads of a 4x4 block or 4 reads of its rightmost column,
// each pixel returned with its block index one cycle after the read, then one drain cycle.
module sad_pixel_fetch
    import sad_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic              col_mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              pix_valid,
    output logic [IDX_W-1:0]  pix_index,
    output logic [PIX_W-1:0]  pix_data,
    output logic              fetch_done
);
    logic [4:0]       cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [4:0]       last;
    logic [1:0]       row, col;

    always_comb begin
        last       = col_mode ? 5'd4 : 5'd16;
        row        = col_mode ? cnt_q[1:0] : cnt_q[3:2];
        col        = col_mode ? 2'd3 : cnt_q[1:0];
        rd_en      = active && (cnt_q < last);
        fetch_done = active && (cnt_q == last);
        rd_addr    = rd_en ? base + ADDR_W'(row) * stride + ADDR_W'(col) : '0;
        // Counter restarts on the drain cycle so back-to-back phases begin at index 0.
        cnt_d      = (active && !fetch_done) ? cnt_q + 5'd1 : 5'd0;
        rd_d       = rd_en;
        idx_d      = pix_idx(row, col);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rd_q  <= 1'b0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            idx_q <= idx_d;
        end
    end

    assign pix_valid = rd_q;
    assign pix_index = idx_q;
    assign pix_data  = rd_data;
endmodule

// File: rtl/sad_window_feeder.sv
// Scans every 4x4 window of a frame in raster order and presents each Crop/Window pair
// with its origin over valid/ready; x-steps within a row fetch only the new column.
module sad_window_feeder
    import sad_pkg::*;
#(
    parameter int FRAME_W   = 64,
    parameter int FRAME_H   = 64,
    parameter int COORD_W   = 8,
    parameter int ADDR_W    = 13,
    parameter int TMPL_BASE = 4096
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Start,
    output logic                Busy,
    output logic                Done,
    output logic                MemRdEn,
    output logic [ADDR_W-1:0]   MemAddr,
    input  logic [PIX_W-1:0]    MemRdData,
    output logic [BLK_BITS-1:0] Crop,
    output logic [BLK_BITS-1:0] Window,
    output logic [COORD_W-1:0]  WinX,
    output logic [COORD_W-1:0]  WinY,
    output logic                WinValid,
    input  logic                WinReady
);
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(FRAME_W - BLK);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(FRAME_H - BLK);

    state_t                state_q, state_d;
    logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
    logic [BLK_BITS-1:0]   crop_q, crop_d, win_q, win_d;

    logic                  fetch_active, fetch_col, fetch_done;
    logic [ADDR_W-1:0]     frame_base, fetch_base, fetch_stride;
    logic                  pix_valid;
    logic [IDX_W-1:0]      pix_index;
    logic [PIX_W-1:0]      pix_data;

    always_comb begin
        fetch_active = (state_q == S_LOAD_TMPL) || (state_q == S_LOAD_FULL) ||
                       (state_q == S_LOAD_COL);
        fetch_col    = (state_q == S_LOAD_COL);
        frame_base   = ADDR_W'(y_q) * ADDR_W'(FRAME_W) + ADDR_W'(x_q);
        fetch_base   = (state_q == S_LOAD_TMPL) ? ADDR_W'(TMPL_BASE) : frame_base;
        fetch_stride = (state_q == S_LOAD_TMPL) ? ADDR_W'(BLK) : ADDR_W'(FRAME_W);
    end

    sad_pixel_fetch #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .active     (fetch_active),
        .col_mode   (fetch_col),
        .base       (fetch_base),
        .stride     (fetch_stride),
        .rd_en      (MemRdEn),
        .rd_addr    (MemAddr),
        .rd_data    (MemRdData),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .pix_data   (pix_data),
        .fetch_done (fetch_done)
    );

    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        crop_d  = crop_q;
        win_d   = win_q;

        if (pix_valid) begin
            if (state_q == S_LOAD_TMPL) crop_d[int'(pix_index) * PIX_W +: PIX_W] = pix_data;
            else                        win_d[int'(pix_index) * PIX_W +: PIX_W]  = pix_data;
        end

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_LOAD_TMPL;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_LOAD_TMPL: if (fetch_done) state_d = S_LOAD_FULL;
            S_LOAD_FULL,
            S_LOAD_COL:  if (fetch_done) state_d = S_PRESENT;
            S_PRESENT: begin
                if (WinReady) begin
                    if (x_q != LAST_X) begin
                        // Slide one column: keep cols 1..3 as 0..2, col 3 refilled by LOAD_COL.
                        for (int r = 0; r < BLK; r++) begin
                            for (int c = 0; c < BLK - 1; c++) begin
                                win_d[int'(pix_idx(2'(r), 2'(c))) * PIX_W +: PIX_W] =
                                    win_q[int'(pix_idx(2'(r), 2'(c + 1))) * PIX_W +: PIX_W];
                            end
                        end
                        x_d     = x_q + COORD_W'(1);
                        state_d = S_LOAD_COL;
                    end else if (y_q != LAST_Y) begin
                        x_d     = '0;
                        y_d     = y_q + COORD_W'(1);
                        state_d = S_LOAD_FULL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the wide Crop/Window registers are reset because they drive outputs that must read 0 in reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            crop_q  <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            crop_q  <= crop_d;
            win_q   <= win_d;
        end
    end

    assign Busy     = (state_q != S_IDLE);
    assign Done     = (state_q == S_DONE);
    assign WinValid = (state_q == S_PRESENT);
    assign Crop     = crop_q;
    assign Window   = win_q;
    assign WinX     = x_q;
    assign WinY     = y_q;
endmodule
